// File: rtl/lock_code_sender.sv
// lock_code_sender: emits an optional reset pulse, then a programmable 0/1 code as
// single-cycle button pulses, with an optional idle gap after every pulse.
module lock_code_sender #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int GAP_W   = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [MAX_LEN-1:0] i_code,
    input  logic [LEN_W-1:0]   i_len,
    input  logic [GAP_W-1:0]   i_gap,
    input  logic               i_send_reset,
    output logic               o_b0_out,
    output logic               o_b1_out,
    output logic               o_rst_out,
    output logic               o_busy,
    output logic               o_done
);
    typedef enum logic [2:0] {S_IDLE, S_RST, S_SYM, S_GAP, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [MAX_LEN-1:0] r_code, w_code_al, w_src;
    logic [LEN_W-1:0]   r_cnt, w_len_c, w_cnt_src;
    logic [GAP_W-1:0]   r_gap, r_gcnt;
    logic               r_b0, r_b1, r_rst, r_busy, r_done;
    logic               w_idle, w_bit;

    assign w_idle    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_len_c   = (i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_len;
    // Left-align the code so the next symbol to send is always the MSB
    assign w_code_al = i_code << (MAX_LEN - int'(w_len_c));
    assign w_src     = w_idle ? w_code_al : r_code;
    assign w_cnt_src = w_idle ? w_len_c : r_cnt;
    assign w_bit     = w_src[MAX_LEN-1];

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE, S_DONE: w_next = !i_start ? S_IDLE : i_send_reset ? S_RST :
                                     (w_len_c != '0) ? S_SYM : S_DONE;
            S_RST, S_SYM:   w_next = i_abort ? S_IDLE : (r_gap != '0) ? S_GAP :
                                     (r_cnt != '0) ? S_SYM : S_DONE;
            S_GAP:          w_next = i_abort ? S_IDLE : (r_gcnt != '0) ? S_GAP :
                                     (r_cnt != '0) ? S_SYM : S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Outputs are registered decodes of the state being entered
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_code <= '0;
            r_cnt  <= '0;
            r_gap  <= '0;
            r_gcnt <= '0;
            r_b0   <= 1'b0;
            r_b1   <= 1'b0;
            r_rst  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_rst  <= (w_next == S_RST);
            r_b0   <= (w_next == S_SYM) && !w_bit;
            r_b1   <= (w_next == S_SYM) && w_bit;
            r_busy <= (w_next == S_RST) || (w_next == S_SYM) || (w_next == S_GAP);
            r_done <= (w_next == S_DONE);
            if (w_idle && i_start) begin
                r_code <= w_code_al;
                r_cnt  <= w_len_c;
                r_gap  <= i_gap;
            end
            if (w_next == S_SYM) begin
                r_code <= w_src << 1;
                r_cnt  <= w_cnt_src - 1'b1;
            end
            if (w_next == S_GAP)
                r_gcnt <= (r_state == S_GAP) ? r_gcnt - 1'b1 : r_gap - 1'b1;
        end
    end

    assign o_b0_out  = r_b0;
    assign o_b1_out  = r_b1;
    assign o_rst_out = r_rst;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
endmodule
